// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_pkg
//  Description : Definitions shared by the fetch unit and the multicycle
//                control unit: fetch FSM state encoding, instruction-register
//                field positions and opcode/funct constants.
//  Revision    : 1.0  initial release
// ============================================================================
package cpu_pkg;

    // Fetch FSM states (2-bit encoding)
    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_READ = 2'b01,
        S_WAIT = 2'b10
    } fetch_state_t;

    // Memory latency counter width (latency range 1..7)
    localparam int c_CNT_W = 3;

    // Instruction-register field bit positions
    localparam int c_OPCODE_HI = 31;
    localparam int c_OPCODE_LO = 26;
    localparam int c_RS_HI     = 25;
    localparam int c_RS_LO     = 21;
    localparam int c_RT_HI     = 20;
    localparam int c_RT_LO     = 16;
    localparam int c_RD_HI     = 15;
    localparam int c_RD_LO     = 11;
    localparam int c_SHAMT_HI  = 10;
    localparam int c_SHAMT_LO  = 6;
    localparam int c_FUNCT_HI  = 5;
    localparam int c_FUNCT_LO  = 0;
    localparam int c_IMM_HI    = 15;
    localparam int c_JADDR_HI  = 25;

    // Opcode constants
    localparam logic [5:0] c_OP_RTYPE = 6'b000000;
    localparam logic [5:0] c_OP_J     = 6'b000010;
    localparam logic [5:0] c_OP_JAL   = 6'b000011;
    localparam logic [5:0] c_OP_BEQ   = 6'b000100;
    localparam logic [5:0] c_OP_BNE   = 6'b000101;
    localparam logic [5:0] c_OP_ADDI  = 6'b001000;
    localparam logic [5:0] c_OP_LW    = 6'b100011;
    localparam logic [5:0] c_OP_SW    = 6'b101011;

    // R-type funct constants
    localparam logic [5:0] c_FN_SLL   = 6'b000000;
    localparam logic [5:0] c_FN_JR    = 6'b001000;
    localparam logic [5:0] c_FN_ADD   = 6'b100000;
    localparam logic [5:0] c_FN_SUB   = 6'b100010;
    localparam logic [5:0] c_FN_AND   = 6'b100100;
    localparam logic [5:0] c_FN_OR    = 6'b100101;
    localparam logic [5:0] c_FN_SLT   = 6'b101010;

endpackage
`default_nettype wire

// File: rtl/instr_fetch_unit_pc_reg.sv
`default_nettype none
// ============================================================================
//  Module      : pc_reg
//  Description : 32-bit program counter with direct load (idle), deferred
//                redirect (fetch in flight) and increment-by-4 at capture.
//  Ports       : clk, reset         - clock, synchronous active-high reset
//                redirect           - accepted PC load this cycle
//                redirect_pc        - load target (already word aligned)
//                busy               - a fetch is in flight
//                capture            - instruction captured this cycle
//                pc / pc_plus4      - current PC and PC+4 (wraps mod 2^32)
//  Revision    : 1.0  initial release
// ============================================================================
module pc_reg
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        busy,
    input  logic        capture,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4
);

    logic [31:0] r_pc;
    logic        r_pend_valid;
    logic [31:0] r_pend_pc;
    logic [31:0] w_pc_plus4;

    assign w_pc_plus4 = r_pc + 32'd4;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc         <= RESET_PC;
            r_pend_valid <= 1'b0;
            r_pend_pc    <= 32'h0;
        end else if (capture) begin
            // A load arriving on the capture cycle is the most recent one,
            // so it beats any earlier pending target.
            if (redirect)
                r_pc <= redirect_pc;
            else if (r_pend_valid)
                r_pc <= r_pend_pc;
            else
                r_pc <= w_pc_plus4;
            r_pend_valid <= 1'b0;
        end else if (redirect) begin
            if (busy) begin
                r_pend_valid <= 1'b1;
                r_pend_pc    <= redirect_pc;
            end else begin
                r_pc <= redirect_pc;
            end
        end
    end

    assign pc       = r_pc;
    assign pc_plus4 = w_pc_plus4;

endmodule
`default_nettype wire

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : instr_fetch_unit
//  Description : Fetch stage. Sequences a fixed-latency instruction-memory
//                read, latches the word into IR and presents decoded fields
//                with a valid flag. Accepts PC redirects from control.
//  Ports       : clk, reset, fetch_req, pc_load, pc_next[31:0],
//                mem_rdata[31:0]  -> inputs
//                mem_addr, mem_rd, busy, ir_valid, opcode, rs, rt, rd, shamt,
//                funct, imm16, jaddr, pc_out, pc_plus4, misaligned -> outputs
//  Options     : FETCH_ALIGN_CHECK_EN - reject misaligned pc_load targets and
//                raise a sticky misaligned flag; otherwise targets are forced
//                to word alignment and misaligned is tied low.
//  Revision    : 1.0  initial release
// ============================================================================
module instr_fetch_unit
    import cpu_pkg::*;
#(
    parameter int unsigned  MEM_LATENCY = 1,
    parameter logic [31:0]  RESET_PC    = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fetch_req,
    input  logic        pc_load,
    input  logic [31:0] pc_next,
    input  logic [31:0] mem_rdata,
    output logic [31:0] mem_addr,
    output logic        mem_rd,
    output logic        busy,
    output logic        ir_valid,
    output logic [5:0]  opcode,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [4:0]  shamt,
    output logic [5:0]  funct,
    output logic [15:0] imm16,
    output logic [25:0] jaddr,
    output logic [31:0] pc_out,
    output logic [31:0] pc_plus4,
    output logic        misaligned
);

    fetch_state_t       r_state;
    fetch_state_t       w_state_next;
    logic [c_CNT_W-1:0] r_cnt;
    logic [31:0]        r_ir;
    logic               r_ir_valid;
    logic               w_capture;
    logic               w_busy;
    logic               w_redirect;
    logic [31:0]        w_redirect_pc;
    logic [31:0]        w_pc;

`ifdef FETCH_ALIGN_CHECK_EN
    logic r_misaligned;

    assign w_redirect    = pc_load && (pc_next[1:0] == 2'b00);
    assign w_redirect_pc = pc_next;

    always_ff @(posedge clk) begin
        if (reset)
            r_misaligned <= 1'b0;
        else if (pc_load && (pc_next[1:0] != 2'b00))
            r_misaligned <= 1'b1;
    end

    assign misaligned = r_misaligned;
`else
    logic w_unused_align_bits;

    assign w_unused_align_bits = ^pc_next[1:0];
    assign w_redirect          = pc_load;
    assign w_redirect_pc       = {pc_next[31:2], 2'b00};
    assign misaligned          = 1'b0;
`endif

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset)
            r_state <= S_IDLE;
        else
            r_state <= w_state_next;
    end

    // ------------------------------------------------------------------
    // FSM: next state and strobes
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_capture    = 1'b0;
        mem_rd       = 1'b0;
        w_busy       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (fetch_req)
                    w_state_next = S_READ;
            end
            S_READ: begin
                mem_rd = 1'b1;
                w_busy = 1'b1;
                // Single-cycle memory: data is sampled at the end of the
                // strobe cycle.
                if (MEM_LATENCY == 1) begin
                    w_capture    = 1'b1;
                    w_state_next = S_IDLE;
                end else begin
                    w_state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                w_busy = 1'b1;
                // Count reaching zero on this edge means data is valid now.
                if (r_cnt == c_CNT_W'(1)) begin
                    w_capture    = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Latency counter, IR and valid flag
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt      <= '0;
            r_ir       <= 32'h0;
            r_ir_valid <= 1'b0;
        end else begin
            if (r_state == S_READ) begin
                r_cnt      <= c_CNT_W'(MEM_LATENCY - 1);
                r_ir_valid <= 1'b0;
            end else if (r_state == S_WAIT) begin
                r_cnt <= r_cnt - c_CNT_W'(1);
            end
            if (w_capture) begin
                r_ir       <= mem_rdata;
                r_ir_valid <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Program counter
    // ------------------------------------------------------------------
    pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk         (clk),
        .reset       (reset),
        .redirect    (w_redirect),
        .redirect_pc (w_redirect_pc),
        .busy        (w_busy),
        .capture     (w_capture),
        .pc          (w_pc),
        .pc_plus4    (pc_plus4)
    );

    assign pc_out   = w_pc;
    assign mem_addr = w_pc;
    assign busy     = w_busy;
    assign ir_valid = r_ir_valid;

    // Decoded fields are plain slices of IR
    assign opcode = r_ir[c_OPCODE_HI:c_OPCODE_LO];
    assign rs     = r_ir[c_RS_HI:c_RS_LO];
    assign rt     = r_ir[c_RT_HI:c_RT_LO];
    assign rd     = r_ir[c_RD_HI:c_RD_LO];
    assign shamt  = r_ir[c_SHAMT_HI:c_SHAMT_LO];
    assign funct  = r_ir[c_FUNCT_HI:c_FUNCT_LO];
    assign imm16  = r_ir[c_IMM_HI:0];
    assign jaddr  = r_ir[c_JADDR_HI:0];

endmodule
`default_nettype wire

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Fetch stage directly upstream of the multicycle control FSM.
- Owns the PC and sequences the instruction-memory read with fixed latency.
- Latches the word into the instruction register (IR) and presents decoded fields (opcode/funct/etc.) to the control unit with a valid flag.
- Accepts PC redirects (branch/jump/exception vector) from the control unit.

Parameters:
- MEM_LATENCY, 1, cycles from mem_rd assertion to mem_rdata valid (legal range 1..7).
- RESET_PC, 32'h0000_0000, PC value after reset.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- fetch_req  in  1  control unit requests the next instruction (1-cycle pulse or level)
- pc_load  in  1  redirect PC to pc_next
- pc_next  in  32  redirect target
- mem_rdata  in  32  instruction memory read data
- mem_addr  out  32  instruction memory address
- mem_rd  out  1  memory read strobe
- busy  out  1  fetch in progress
- ir_valid  out  1  IR holds a fresh instruction not yet superseded
- opcode  out  6  IR[31:26]
- rs  out  5  IR[25:21]
- rt  out  5  IR[20:16]
- rd  out  5  IR[15:11]
- shamt  out  5  IR[10:6]
- funct  out  6  IR[5:0]
- imm16  out  16  IR[15:0]
- jaddr  out  26  IR[25:0]
- pc_out  out  32  current PC (address of next fetch)
- pc_plus4  out  32  pc_out + 4, mod 2^32
- misaligned  out  1  alignment error flag (see Optional Feature)

Behaviour:
- Reset (synchronous; also aborts any in-flight fetch):
  - PC=RESET_PC, IR=0, ir_valid=0, mem_rd=0, busy=0, misaligned=0, pending-redirect=0, state=S_IDLE.
- FSM states: S_IDLE, S_READ, S_WAIT.
- S_IDLE:
  - If pc_load=1: PC<=pc_next.
  - If fetch_req=1: state<=S_READ. The fetch address is pc_next when pc_load=1 in the same cycle, otherwise PC.
  - ir_valid is held.
- S_READ:
  - mem_rd=1, mem_addr=PC, busy=1, ir_valid<=0, latency counter<=MEM_LATENCY-1.
  - If MEM_LATENCY=1: go to the capture step next cycle. Otherwise go to S_WAIT.
- S_WAIT:
  - busy=1, mem_rd=0, mem_addr holds PC.
  - Counter decrements each cycle; at 0, capture occurs.
- Capture (on the cycle mem_rdata is valid):
  - IR<=mem_rdata.
  - PC<=pending-redirect target if set, else PC+4.
  - ir_valid<=1, busy<=0, state<=S_IDLE.
- Latency: fetch_req in cycle N; mem_rd in N+1; IR/ir_valid visible in N+1+MEM_LATENCY.
- pc_load during S_READ/S_WAIT: target is latched into the pending-redirect register and applied at capture, overriding PC+4. The last such load wins. Pending is cleared at capture.
- fetch_req while busy=1: ignored, not queued.
- Decoded field outputs are pure slices of IR (combinational from IR). They are stable while in S_IDLE.
- pc_plus4 wraps: 32'hFFFF_FFFC + 4 = 0.
- mem_addr when idle = PC.

Optional Feature:
- Macro: FETCH_ALIGN_CHECK_EN.
- With the macro defined:
  - pc_load with pc_next[1:0]!=2'b00 does not modify PC (or pending-redirect).
  - misaligned<=1, sticky until reset.
  - A fetch_req in the same cycle uses the unchanged PC.
- Without the macro:
  - misaligned is tied 0.
  - pc_next is loaded with bits [1:0] forced to 2'b00.

Decomposition:
- Shared package (cpu_pkg):
  - FSM state encodings (S_IDLE/S_READ/S_WAIT, 2 bits).
  - IR field bit-positions.
  - Opcode/funct constants (R=6'b000000, ADD=6'b100000, …), shared with the control unit.
- Sub-module pc_reg: 32-bit PC with load/increment/pending-redirect logic. The FSM stays in instr_fetch_unit.

Test Plan:
- Reset, then fetch_req with mem_rdata=32'h0128_5020 (MEM_LATENCY=1) -> mem_rd high 1 cycle at addr 0; next cycle ir_valid=1, opcode=0, rs=9, rt=8, rd=10, funct=6'h20; pc_out=4.
- MEM_LATENCY=3, fetch_req at cycle 10 -> mem_rd only in cycle 11, busy 11..13, ir_valid=1 from cycle 14; second fetch_req during cycle 12 is ignored.
- pc_load=1, pc_next=32'h0000_0040 during S_WAIT -> after capture pc_out=32'h40 (not old PC+4), and the next fetch reads address 0x40.
- pc_load and fetch_req in the same cycle in S_IDLE, pc_next=32'h100 -> mem_addr=32'h100 at the mem_rd cycle; pc_out=32'h104 after capture.
- Assert reset in S_WAIT -> next cycle ir_valid=0, busy=0, pc_out=RESET_PC; the late mem_rdata is not captured.
- FETCH_ALIGN_CHECK_EN: pc_load with pc_next=32'h0000_0042 -> misaligned=1, pc_out unchanged; stays 1 until reset.
